// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the wide adder sequencer and its slice adder.
package adder_pkg;

  localparam int DEFAULT_N = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Slice index width; a single-bit index is kept even when WORDS is tiny.
  function automatic int idx_width(input int words);
    return ($clog2(words) < 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational N-bit adder; the sequencer reuses one instance for every slice.
module slice_adder
  import adder_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};

endmodule

// File: rtl/wide_adder_top.sv
// Integration wrapper: the sequencer plus the single N-bit adder it time-shares.
module wide_adder_top
  import adder_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] op_a,
  input  logic [N*WORDS-1:0] op_b,
  input  logic               op_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] result,
  output logic               result_cout,
  output logic               result_ovf,
  output logic               busy
);

  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic [N-1:0] add_sum;
  logic         add_cin;
  logic         add_cout;

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) u_seq (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_cout (result_cout),
    .result_ovf  (result_ovf),
    .busy        (busy)
  );

  slice_adder #(.n(N)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

endmodule

// File: rtl/wide_add_sequencer.sv
// Sequences one N*WORDS-bit addition through an external N-bit adder,
// least-significant slice first, with the carry chained through carry_q.
module wide_add_sequencer
  import adder_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] op_a,
  input  logic [N*WORDS-1:0] op_b,
  input  logic               op_cin,
  output logic [N-1:0]       add_a,
  output logic [N-1:0]       add_b,
  output logic               add_cin,
  input  logic [N-1:0]       add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] result,
  output logic               result_cout,
  output logic               result_ovf,
  output logic               busy
);

  localparam int IW = idx_width(WORDS);
  localparam int W  = N * WORDS;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic [W-1:0]  op_a_q;
  logic [W-1:0]  op_b_q;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = op_a_q[idx*N +: N];
      add_b   = op_b_q[idx*N +: N];
      add_cin = carry_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry_q     <= 1'b0;
      // NOTE: operand registers are cleared too, so a reset leaves no stale data to observe.
      op_a_q      <= '0;
      op_b_q      <= '0;
      result      <= '0;
      result_cout <= 1'b0;
      result_ovf  <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a_q  <= op_a;
            op_b_q  <= op_b;
            carry_q <= op_cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          result[idx*N +: N] <= add_sum;
          carry_q            <= add_cout;
          if (idx == LAST_IDX) begin
            result_cout <= add_cout;
            // Signed overflow: like-signed operands producing a sum of the other sign.
            result_ovf  <= (op_a_q[W-1] == op_b_q[W-1]) && (add_sum[N-1] != op_a_q[W-1]);
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: directed cases from the plan plus random operands,
// checked against whole-width integer arithmetic.
module tb_wide_add_sequencer;

  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_cout;
  logic         result_ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_cout (result_cout),
    .result_ovf  (result_ovf),
    .busy        (busy)
  );

  slice_adder #(.n(N)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the whole addition as one integer sum.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
    logic [W:0] s;
    s = ref_sum(a, b, cin);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Drive one request on a negedge; the next posedge accepts it.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = {$urandom(), $urandom()};
    op_b     = {$urandom(), $urandom()};
    op_cin   = 1'($urandom());
  endtask

  // Called at the first negedge after the accept edge; ends with out_valid seen.
  task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input string tag);
    int         edges;
    logic [N:0] s0;
    logic [W:0] s;
    edges = 0;
    s0 = {1'b0, a[N-1:0]} + {1'b0, b[N-1:0]} + {{N{1'b0}}, cin};
    s  = ref_sum(a, b, cin);
    check({tag, "_busy"}, 64'(busy), 64'(1));
    check({tag, "_in_ready_run"}, 64'(in_ready), 64'(0));
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
      if (edges == 1) check({tag, "_cin_slice1"}, 64'(add_cin), 64'(s0[N]));
    end
    check({tag, "_latency"}, 64'(edges), 64'(WORDS));
    check({tag, "_result"}, 64'(result), 64'(s[W-1:0]));
    check({tag, "_cout"}, 64'(result_cout), 64'(s[W]));
    check({tag, "_ovf"}, 64'(result_ovf), 64'(ref_ovf(a, b, cin)));
    check({tag, "_add_a_idle"}, 64'(add_a), 64'(0));
  endtask

  task automatic release_result(input string tag, input logic [W-1:0] exp_result);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1));
    check({tag, "_result_held"}, 64'(result), 64'(exp_result));
  endtask

  task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input string tag);
    logic [W:0] s;
    s = ref_sum(a, b, cin);
    accept(a, b, cin);
    wait_result(a, b, cin, tag);
    release_result(tag, s[W-1:0]);
  endtask

  initial begin
    logic [W-1:0] ra, rb, bp_res;
    logic         rc;
    logic [W:0]   s;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_cout", 64'(result_cout), 64'(0));
    check("rst_ovf", 64'(result_ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_add_cin", 64'(add_cin), 64'(0));

    full_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, "carry_slice0");
    full_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "wrap_all");
    full_op(64'h0, 64'h0, 1'b1, "cin_only");
    full_op(64'h0, 64'h0, 1'b0, "no_stale_carry");
    full_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "pos_ovf");
    full_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "neg_ovf");

    // Backpressure: result held in DONE, new requests ignored until release.
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    rc = 1'($urandom());
    s  = ref_sum(ra, rb, rc);
    bp_res = s[W-1:0];
    accept(ra, rb, rc);
    wait_result(ra, rb, rc, "bp_first");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      op_a     = 64'h1234_5678_9ABC_DEF0;
      op_b     = 64'h1;
      op_cin   = 1'b0;
      @(negedge clk);
      check("bp_result_stable", 64'(result), 64'(bp_res));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_idle", 64'(in_ready), 64'(1));
    check("bp_release_valid", 64'(out_valid), 64'(0));
    accept(64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0);
    wait_result(64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0, "bp_second");
    release_result("bp_second", 64'h1234_5678_9ABC_DEF1);

    // Reset while the third slice is being added.
    accept(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_add_a", 64'(add_a), 64'(0));
    check("midrst_add_b", 64'(add_b), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    check("midrst_no_valid", 64'(out_valid), 64'(0));
    full_op(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b1, "after_rst");

    for (int i = 0; i < 10; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom());
      full_op(ra, rb, rc, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
